keypad_digit_entry: RTL and testbench



---
 rtl/keypad_digit_entry.sv | 127 ++++++++++++
 tb/tb_keypad_digit_entry.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_entry.sv
// rtl/keypad_digit_entry.sv - debounced BCD key entry into an N-digit buffer with valid/ready hand-off
module keypad_digit_entry #(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   bcd_in,
    input  logic                         key_down,
    input  logic                         enter,
    input  logic                         clear,
    output logic [4*DIGITS-1:0]          digits_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int KW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    state_t        state, state_next;
    logic [KW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    code, code_next;
    logic          commit;
    logic          stored;
    logic [W-1:0]  shifted;

    // Saturating increment: the counter must never wrap back to zero
    assign cnt_inc = (cnt == KW'(DEBOUNCE)) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            code  <= code_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (key_down) begin
                    code_next  = bcd_in;
                    cnt_next   = KW'(1);
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (!key_down) begin
                    state_next = IDLE;
                end else if (bcd_in != code) begin
                    code_next = bcd_in;
                    cnt_next  = KW'(1);
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == KW'(DEBOUNCE)) begin
                        commit     = 1'b1;
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (!key_down) begin
                    cnt_next   = KW'(1);
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (key_down) begin
                    state_next = HELD;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == KW'(DEBOUNCE)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A digit actually lands in the buffer only when it is legal, there is room and nothing is on offer
    assign stored  = commit && !out_valid && (code <= 4'd9) && (digit_count != CW'(DIGITS));
    assign shifted = (digits_out << 4) | W'(code);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_out  <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else if (clear) begin
            digits_out  <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else if (out_valid && out_ready) begin
            digits_out  <= '0;
            digit_count <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (commit && !out_valid && !stored) begin
                err <= 1'b1;
            end
            if (stored) begin
                digits_out  <= shifted;
                digit_count <= digit_count + 1'b1;
            end
            if (enter && !out_valid && ((digit_count != '0) || stored)) begin
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// tb/tb_keypad_digit_entry.sv - directed tables, corner sequences and random traffic against a run-length model
module tb_keypad_digit_entry;

    localparam int DIGITS   = 4;
    localparam int DEBOUNCE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  bcd_in;
    logic        key_down;
    logic        enter;
    logic        clear;
    logic [15:0] digits_out;
    logic [2:0]  digit_count;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    keypad_digit_entry #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bcd_in      (bcd_in),
        .key_down    (key_down),
        .enter       (enter),
        .clear       (clear),
        .digits_out  (digits_out),
        .digit_count (digit_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: a press is DEBOUNCE consecutive high samples of one code; re-arm after DEBOUNCE consecutive lows
    bit         m_armed;
    int         m_run;
    int         m_low;
    logic [3:0] m_last;
    int         m_q[$];
    bit         m_valid;
    bit         m_err;

    function automatic logic [15:0] m_value();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_armed = 1;
        m_run   = 0;
        m_low   = 0;
        m_last  = '0;
        m_q.delete();
        m_valid = 0;
        m_err   = 0;
    endtask

    task automatic model_step();
        bit commit = 0;
        if (m_armed) begin
            if (key_down) begin
                if (m_run > 0 && bcd_in == m_last) m_run++;
                else begin
                    m_run  = 1;
                    m_last = bcd_in;
                end
                if (m_run == DEBOUNCE) begin
                    commit  = 1;
                    m_armed = 0;
                    m_low   = 0;
                end
            end else m_run = 0;
        end else begin
            if (!key_down) begin
                m_low++;
                if (m_low == DEBOUNCE) begin
                    m_armed = 1;
                    m_run   = 0;
                end
            end else m_low = 0;
        end
        if (clear) begin
            m_q.delete();
            m_valid = 0;
            m_err   = 0;
        end else if (m_valid && out_ready) begin
            m_q.delete();
            m_valid = 0;
        end else begin
            if (commit && !m_valid) begin
                if (m_last > 9) m_err = 1;
                else if (m_q.size() == DIGITS) m_err = 1;
                else m_q.push_back(int'(m_last));
            end
            if (enter && !m_valid && m_q.size() > 0) m_valid = 1;
        end
    endtask

    task automatic step(input bit kd, input logic [3:0] code, input bit en, input bit clr, input bit rdy);
        key_down  = kd;
        bcd_in    = code;
        enter     = en;
        clear     = clr;
        out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cyc_digits", digits_out, m_value());
        check("cyc_count", digit_count, m_q.size());
        check("cyc_valid", out_valid, m_valid);
        check("cyc_err", err, m_err);
    endtask

    task automatic press(input logic [3:0] code, input int hi, input int lo);
        repeat (hi) step(1, code, 0, 0, 0);
        repeat (lo) step(0, code, 0, 0, 0);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp_digits;
        int          exp_count;
        bit          exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int prev;
        bit kd_r;
        logic [3:0] code_r;

        tbl[0] = '{4'd1, 16'h0001, 1, 1'b0};
        tbl[1] = '{4'd9, 16'h0019, 2, 1'b0};
        tbl[2] = '{4'd0, 16'h0190, 3, 1'b0};
        tbl[3] = '{4'd5, 16'h1905, 4, 1'b0};
        tbl[4] = '{4'd3, 16'h1905, 4, 1'b1};

        rst_n = 0; key_down = 0; bcd_in = 0; enter = 0; clear = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_digits", digits_out, 0);
        check("rst_count", digit_count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_err", err, 0);
        rst_n = 1;
        model_reset();

        prev = 0;
        foreach (tbl[i]) begin
            repeat (DEBOUNCE - 1) step(1, tbl[i].code, 0, 0, 0);
            check("tbl_precommit_count", digit_count, prev);
            step(1, tbl[i].code, 0, 0, 0);
            repeat (DEBOUNCE) step(0, tbl[i].code, 0, 0, 0);
            check("tbl_digits", digits_out, tbl[i].exp_digits);
            check("tbl_count", digit_count, tbl[i].exp_count);
            check("tbl_err", err, tbl[i].exp_err);
            prev = tbl[i].exp_count;
        end

        step(0, 0, 0, 1, 0);
        check("clear_digits", digits_out, 0);
        check("clear_count", digit_count, 0);
        check("clear_err", err, 0);

        step(1, 7, 0, 0, 0); step(0, 7, 0, 0, 0);
        step(1, 7, 0, 0, 0); step(1, 7, 0, 0, 0); step(0, 7, 0, 0, 0);
        repeat (3) step(1, 7, 0, 0, 0);
        check("bounce_nocommit", digit_count, 0);
        step(1, 7, 0, 0, 0);
        check("bounce_commit_count", digit_count, 1);
        check("bounce_commit_digits", digits_out, 16'h0007);
        step(0, 7, 0, 0, 0); step(0, 7, 0, 0, 0); step(1, 7, 0, 0, 0);
        repeat (4) step(1, 7, 0, 0, 0);
        repeat (DEBOUNCE) step(0, 7, 0, 0, 0);
        check("bounce_single7", digits_out, 16'h0007);

        step(0, 0, 0, 1, 0);
        step(1, 3, 0, 0, 0);
        repeat (4) step(1, 6, 0, 0, 0);
        repeat (DEBOUNCE) step(0, 6, 0, 0, 0);
        check("chg_digits", digits_out, 16'h0006);
        check("chg_count", digit_count, 1);

        step(0, 0, 0, 1, 0);
        press(4'hC, 4, 4);
        check("illegal_count", digit_count, 0);
        check("illegal_err", err, 1);
        step(0, 0, 0, 1, 0);
        check("illegal_clear_err", err, 0);

        press(8, 4, 4);
        press(2, 4, 4);
        step(0, 0, 1, 0, 0);
        check("enter_valid", out_valid, 1);
        check("enter_digits", digits_out, 16'h0082);
        press(3, 4, 4);
        check("valid_press_digits", digits_out, 16'h0082);
        check("valid_press_count", digit_count, 2);
        repeat (5) begin
            step(0, 0, 0, 0, 0);
            check("hold_digits", digits_out, 16'h0082);
            check("hold_valid", out_valid, 1);
        end
        step(0, 0, 0, 0, 1);
        check("xfer_valid", out_valid, 0);
        check("xfer_count", digit_count, 0);
        check("xfer_digits", digits_out, 0);

        press(4, 4, 4);
        step(1, 5, 0, 0, 0); step(1, 5, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        check("midrst_digits", digits_out, 0);
        check("midrst_count", digit_count, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_err", err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, 5, 0, 0, 0);
        check("midrst_restart", digit_count, 0);

        kd_r = 0;
        code_r = 0;
        repeat (2500) begin
            if ($urandom_range(0, 5) == 0) kd_r = !kd_r;
            if ($urandom_range(0, 9) == 0) code_r = 4'($urandom_range(0, 11));
            step(kd_r, code_r, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
